input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 104 ++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Input conditioner: 2-flop synchronizers plus an independent debouncer on each
// of six raw inputs, and a registered one-cycle strobe on the debounced load press.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load_raw,
  input  logic       sw_dir_raw,
  input  logic [3:0] sw_data_raw,
  output logic       load_level,
  output logic       load_pulse,
  output logic       up_down,
  output logic [3:0] data_out
);

  localparam int unsigned N  = 6;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_t;

  logic [N-1:0]  raw;
  logic [N-1:0]  meta;
  logic [N-1:0]  synced;
  logic [N-1:0]  debounced;
  logic [N-1:0]  debounced_next;
  logic [CW-1:0] count      [N];
  logic [CW-1:0] count_next [N];
  db_state_t     state      [N];
  db_state_t     state_next [N];

  // Channel 0 is the load button, 1 the direction switch, 5:2 the data switches.
  assign raw = {sw_data_raw, sw_dir_raw, btn_load_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    debounced_next = debounced;
    for (int unsigned i = 0; i < N; i++) begin
      case (state[i])
        STABLE: begin
          if (synced[i] != debounced[i]) begin
            state_next[i] = CHANGING;
            count_next[i] = CW'(1);
          end
        end
        CHANGING: begin
          if (synced[i] == debounced[i]) begin
            state_next[i] = STABLE;
            count_next[i] = '0;
          end else if (count[i] == LAST) begin
            // Accept on the edge that would have taken the count to DEBOUNCE_CYCLES.
            state_next[i]     = STABLE;
            count_next[i]     = '0;
            debounced_next[i] = ~debounced[i];
          end else begin
            count_next[i] = count[i] + CW'(1);
          end
        end
        default: begin
          state_next[i] = STABLE;
          count_next[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        state[i] <= STABLE;
        count[i] <= '0;
      end
      debounced  <= '0;
      load_pulse <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state[i] <= state_next[i];
        count[i] <= count_next[i];
      end
      debounced  <= debounced_next;
      load_pulse <= ~debounced[0] & debounced_next[0];
    end
  end

  assign load_level = debounced[0];
  assign up_down    = debounced[1];
  assign data_out   = debounced[5:2];

endmodule
